// File: rtl/digit_entry_ctrl.sv
// Button/switch front-end for the 8-digit display block: synchronizes raw inputs,
// debounces the buttons and turns each press into single-cycle write commands.
module digit_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int N_DIGITS        = 8,
    parameter int SEL_W           = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_wr,
    input  logic             btn_clr,
    input  logic [3:0]       sw_num,
    input  logic [SEL_W-1:0] sw_sel,
    input  logic             auto_inc,
    output logic             write,
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       num,
    output logic [SEL_W-1:0] ptr,
    output logic             busy
);
    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, HOLD} state_t;

    // Button vectors: bit 0 is the write button, bit 1 the clear button.
    logic [1:0]       btn_s1_q, btn_s2_q;
    logic [3:0]       num_s1_q, num_s2_q;
    logic [SEL_W-1:0] sel_s1_q, sel_s2_q;
    logic             auto_s1_q, auto_s2_q;
    logic [1:0]       deb_q, deb_d, deb_d1_q, rise;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_t           state_q, state_d;
    logic [SEL_W-1:0] clr_idx_q, clr_idx_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             write_q, write_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]       num_q, num_d;
    logic             busy_q, busy_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (btn_s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb_q & ~deb_d1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            num_s1_q  <= '0;
            num_s2_q  <= '0;
            sel_s1_q  <= '0;
            sel_s2_q  <= '0;
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
            deb_q     <= '0;
            deb_d1_q  <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            btn_s1_q  <= {btn_clr, btn_wr};
            btn_s2_q  <= btn_s1_q;
            num_s1_q  <= sw_num;
            num_s2_q  <= num_s1_q;
            sel_s1_q  <= sw_sel;
            sel_s2_q  <= sel_s1_q;
            auto_s1_q <= auto_inc;
            auto_s2_q <= auto_s1_q;
            deb_q     <= deb_d;
            deb_d1_q  <= deb_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ptr_d     = ptr_q;
        write_d   = 1'b0;
        sel_d     = '0;
        num_d     = '0;
        case (state_q)
            IDLE: begin
                // Clear wins when both buttons rise together.
                if (rise[1]) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end else if (rise[0]) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                write_d = 1'b1;
                num_d   = num_s2_q;
                if (auto_s2_q) begin
                    sel_d = ptr_q;
                    ptr_d = (ptr_q == SEL_LAST) ? '0 : ptr_q + 1'b1;
                end else begin
                    sel_d = sel_s2_q;
                end
                state_d = HOLD;
            end
            CLEAR: begin
                write_d   = 1'b1;
                sel_d     = clr_idx_q;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == SEL_LAST) begin
                    ptr_d     = '0;
                    clr_idx_d = '0;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // Stay here until both buttons are released so a held key cannot repeat.
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            ptr_q     <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            num_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ptr_q     <= ptr_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            num_q     <= num_d;
            busy_q    <= busy_d;
        end
    end

    assign write = write_q;
    assign sel   = sel_q;
    assign num   = num_q;
    assign ptr   = ptr_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Randomized and directed bench for digit_entry_ctrl against a transaction-level
// model built from stable-run debouncing and a queue of scheduled strobes.
module tb_digit_entry_ctrl;
    localparam int D  = 4;
    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_wr, btn_clr, auto_inc;
    logic [3:0]    sw_num;
    logic [SW-1:0] sw_sel;
    logic          write, busy;
    logic [SW-1:0] sel, ptr;
    logic [3:0]    num;

    digit_entry_ctrl #(.DEBOUNCE_CYCLES(D), .N_DIGITS(N), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset), .btn_wr(btn_wr), .btn_clr(btn_clr),
        .sw_num(sw_num), .sw_sel(sw_sel), .auto_inc(auto_inc),
        .write(write), .sel(sel), .num(num), .ptr(ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit wr; bit clr; bit ai; bit [3:0] num; bit [SW-1:0] sel; } raw_t;
    typedef struct { int sel; int num; bit ptr_upd; int ptr_new; } ent_t;
    typedef struct { int sel; int num; int cyc; } cap_t;

    raw_t  d1, d2;
    bit    m_deb  [2];
    int    m_run  [2];
    bit    m_rose [2];
    ent_t  sched [$];
    bit    m_busy;
    int    m_ptr;
    int    exp_write, exp_sel, exp_num;
    cap_t  cap [$];
    int    cyc = 0;

    task automatic model_reset();
        d1 = '{default: 0};
        d2 = '{default: 0};
        for (int b = 0; b < 2; b++) begin
            m_deb[b] = 0; m_run[b] = 0; m_rose[b] = 0;
        end
        sched.delete();
        m_busy = 0; m_ptr = 0;
        exp_write = 0; exp_sel = 0; exp_num = 0;
    endtask

    task automatic model_step(input raw_t cur);
        raw_t sv;
        ent_t e;
        bit   s;
        sv = d2;
        exp_write = 0; exp_sel = 0; exp_num = 0;
        if (!m_busy) begin
            if (m_rose[1]) begin
                for (int i = 0; i < N; i++) begin
                    e.sel = i; e.num = 0; e.ptr_upd = (i == N - 1); e.ptr_new = 0;
                    sched.push_back(e);
                end
                m_busy = 1;
            end else if (m_rose[0]) begin
                // The strobe cycle sees the switches one sample later than this edge.
                e.sel     = d1.ai ? m_ptr : int'(d1.sel);
                e.num     = int'(d1.num);
                e.ptr_upd = d1.ai;
                e.ptr_new = (m_ptr + 1) % N;
                sched.push_back(e);
                m_busy = 1;
            end
        end else if (sched.size() > 0) begin
            e = sched.pop_front();
            exp_write = 1; exp_sel = e.sel; exp_num = e.num;
            if (e.ptr_upd) m_ptr = e.ptr_new;
        end else if (!m_deb[0] && !m_deb[1]) begin
            m_busy = 0;
        end
        // A button level is accepted after D consecutive differing samples.
        for (int b = 0; b < 2; b++) begin
            s = (b == 1) ? sv.clr : sv.wr;
            m_rose[b] = 0;
            if (s != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == D) begin
                    m_deb[b] = s; m_run[b] = 0; m_rose[b] = s;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        d2 = d1;
        d1 = cur;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        raw_t cur;
        cap_t c;
        cur.wr = btn_wr; cur.clr = btn_clr; cur.ai = auto_inc; cur.num = sw_num; cur.sel = sw_sel;
        @(posedge clk);
        cyc++;
        model_step(cur);
        #1;
        check("write", 32'(write), 32'(exp_write));
        check("sel",   32'(sel),   32'(exp_sel));
        check("num",   32'(num),   32'(exp_num));
        check("ptr",   32'(ptr),   32'(m_ptr));
        check("busy",  32'(busy),  32'(m_busy));
        if (write === 1'b1) begin
            c.sel = int'(sel); c.num = int'(num); c.cyc = cyc;
            cap.push_back(c);
        end
    endtask

    task automatic press_wr(input int hi, input int lo);
        btn_wr = 1'b1;
        repeat (hi) step();
        btn_wr = 1'b0;
        repeat (lo) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_write"}, 32'(write), 32'd0);
        check({tag, "_sel"},   32'(sel),   32'd0);
        check({tag, "_num"},   32'(num),   32'd0);
        check({tag, "_ptr"},   32'(ptr),   32'd0);
        check({tag, "_busy"},  32'(busy),  32'd0);
    endtask

    task automatic reset_mid();
        #2 reset = 1'b1;
        #1 check_zero("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1 check_zero("rst_held");
        end
        btn_wr = 1'b0; btn_clr = 1'b0;
        reset = 1'b0;
        model_reset();
        step();
        check_zero("rst_release");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int set_cyc;
        reset = 1'b1; btn_wr = 1'b0; btn_clr = 1'b0; auto_inc = 1'b0;
        sw_num = 4'h0; sw_sel = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("por");
        reset = 1'b0;
        repeat (3) step();

        // Bouncing write button, then a clean press.
        cap.delete();
        sw_num = 4'h6; sw_sel = 3'd2;
        repeat (5) begin
            btn_wr = 1'b1; repeat (2) step();
            btn_wr = 1'b0; repeat (2) step();
        end
        btn_wr = 1'b1;
        set_cyc = cyc;
        repeat (20) step();
        btn_wr = 1'b0;
        repeat (20) step();
        check("bounce_pulses", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) check("bounce_latency", 32'(cap[0].cyc - set_cyc), 32'd8);

        // Auto-increment across the wrap.
        cap.delete();
        auto_inc = 1'b1; sw_num = 4'hA;
        repeat (4) step();
        repeat (9) press_wr(10, 10);
        check("auto_pulses", 32'(cap.size()), 32'd9);
        foreach (cap[i]) begin
            check("auto_sel", 32'(cap[i].sel), 32'(i % 8));
            check("auto_num", 32'(cap[i].num), 32'hA);
        end
        check("auto_ptr_end", 32'(ptr), 32'd1);

        // Manual select leaves the pointer alone.
        cap.delete();
        auto_inc = 1'b0; sw_sel = 3'd5; sw_num = 4'h3;
        repeat (4) step();
        press_wr(10, 12);
        check("man_pulses", 32'(cap.size()), 32'd1);
        if (cap.size() > 0) begin
            check("man_sel", 32'(cap[0].sel), 32'd5);
            check("man_num", 32'(cap[0].num), 32'd3);
        end
        check("man_ptr", 32'(ptr), 32'd1);

        // Reset in the middle of a clear sweep.
        btn_clr = 1'b1;
        repeat (11) step();
        check("pre_rst_write", 32'(write), 32'd1);
        reset_mid();
        repeat (12) step();
        check("post_rst_pulses_none", 32'(write), 32'd0);

        // Simultaneous clear and write presses.
        cap.delete();
        btn_wr = 1'b1; btn_clr = 1'b1;
        repeat (25) step();
        check("clr_busy_held", 32'(busy), 32'd1);
        check("clr_pulses", 32'(cap.size()), 32'd8);
        foreach (cap[i]) begin
            check("clr_sel", 32'(cap[i].sel), 32'(i));
            check("clr_num", 32'(cap[i].num), 32'd0);
        end
        if (cap.size() == 8) check("clr_contiguous", 32'(cap[7].cyc - cap[0].cyc), 32'd7);
        btn_wr = 1'b0; btn_clr = 1'b0;
        repeat (15) step();
        check("clr_busy_released", 32'(busy), 32'd0);
        check("clr_ptr", 32'(ptr), 32'd0);

        // Long hold gives one strobe only.
        cap.delete();
        auto_inc = 1'b1; sw_num = 4'h9;
        repeat (4) step();
        btn_wr = 1'b1;
        repeat (100) step();
        check("hold_pulses", 32'(cap.size()), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        btn_wr = 1'b0;
        repeat (15) step();
        check("hold_idle", 32'(busy), 32'd0);
        cap.delete();
        press_wr(10, 12);
        check("hold_repress", 32'(cap.size()), 32'd1);

        // Random buttons and switches against the model.
        repeat (3000) begin
            if ($urandom_range(5) == 0)  btn_wr   = ~btn_wr;
            if ($urandom_range(11) == 0) btn_clr  = ~btn_clr;
            if ($urandom_range(19) == 0) auto_inc = ~auto_inc;
            if ($urandom_range(7) == 0)  sw_num   = 4'($urandom);
            if ($urandom_range(7) == 0)  sw_sel   = SW'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
